// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS-subset control unit.
// Holds the FSM state type, opcode/funct constants, ALU control codes and
// the mux-select encodings used by the controller and the datapath.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    StFetch,
    StDecode,
    StMemAdr,
    StMemRd,
    StMemWb,
    StMemWr,
    StExec,
    StAluWb,
    StBranch,
    StAddiEx,
    StAddiWb,
    StJump,
    StIllegal,
    StHalt
  } state_e;

  // Opcodes, instr[31:26]
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type funct field, instr[5:0]
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // ALU control codes, shared with the ALU
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // ALU operand B select
  localparam logic [1:0] SRCB_RT      = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  // Next-PC source select
  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_alu_dec.sv
// R-type funct to ALU control lookup.
// Ports:
//   funct       - instr[5:0]
//   alu_ctrl    - ALU operation code (000 when funct is unsupported)
//   funct_valid - 1 when funct is one of add/sub/and/or/slt
module mc_alu_dec
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] alu_ctrl,
  output logic       funct_valid
);

  always_comb begin
    alu_ctrl    = 3'b000;
    funct_valid = 1'b1;
    case (funct)
      FN_ADD:  alu_ctrl = ALU_ADD;
      FN_SUB:  alu_ctrl = ALU_SUB;
      FN_AND:  alu_ctrl = ALU_AND;
      FN_OR:   alu_ctrl = ALU_OR;
      FN_SLT:  alu_ctrl = ALU_SLT;
      default: funct_valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle control unit for a MIPS-subset datapath with a shared
// instruction/data memory port. One Moore state per cycle, memory-ready
// stalls in FETCH/MEMRD/MEMWR, illegal-opcode flag and retire counter.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   opcode, funct     - instruction fields from the IR
//   zero              - ALU zero flag (qualifies pc_write_cond in the datapath)
//   mem_ready         - shared memory access complete
//   pc_write .. pc_src - datapath strobes and mux selects
//   illegal           - one-cycle pulse on unsupported opcode/funct
//   halted            - parked in HALT
//   instr_count       - retired instruction count, wraps
module mc_ctrl_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W        = 32,
  parameter bit          ILLEGAL_HALT = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [2:0]       alu_ctrl,
  output logic [1:0]       pc_src,
  output logic             illegal,
  output logic             halted,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q;
  logic             retire;
  logic [2:0]       dec_alu_ctrl;
  logic             funct_valid;

  // The branch decision is made by the datapath (pc_write_cond & zero).
  logic unused_zero;
  assign unused_zero = zero;

  mc_alu_dec u_alu_dec (
    .funct       (funct),
    .alu_ctrl    (dec_alu_ctrl),
    .funct_valid (funct_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StFetch;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      if (retire) count_q <= count_q + CntOne;
    end
  end

  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    case (state_q)
      StFetch:  if (mem_ready) state_d = StDecode;
      StDecode: begin
        case (opcode)
          OP_LW, OP_SW: state_d = StMemAdr;
          OP_RTYPE:     state_d = StExec;
          OP_BEQ:       state_d = StBranch;
          OP_ADDI:      state_d = StAddiEx;
          OP_J:         state_d = StJump;
          default:      state_d = StIllegal;
        endcase
      end
      StMemAdr: state_d = (opcode == OP_SW) ? StMemWr : StMemRd;
      StMemRd:  if (mem_ready) state_d = StMemWb;
      StMemWr: begin
        if (mem_ready) begin
          retire  = 1'b1;
          state_d = StFetch;
        end
      end
      StExec:   state_d = funct_valid ? StAluWb : StIllegal;
      StAddiEx: state_d = StAddiWb;
      StMemWb, StAluWb, StBranch, StAddiWb, StJump: begin
        retire  = 1'b1;
        state_d = StFetch;
      end
      StIllegal: state_d = ILLEGAL_HALT ? StHalt : StFetch;
      StHalt:    state_d = StHalt;
      default:   state_d = StFetch;
    endcase
  end

  // Outputs decode state_q only (plus funct in EXEC, mem_ready in FETCH).
  // Held at zero while rst is high so no strobe fires in the reset cycle.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_ctrl      = 3'b000;
    pc_src        = 2'b00;
    illegal       = 1'b0;
    halted        = 1'b0;
    if (!rst) begin
      case (state_q)
        StFetch: begin
          mem_read  = 1'b1;
          alu_src_b = SRCB_FOUR;
          alu_ctrl  = ALU_ADD;
          pc_src    = PC_SRC_ALU;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        StDecode: begin
          alu_src_b = SRCB_IMM_SH2;
          alu_ctrl  = ALU_ADD;
        end
        StMemAdr, StAddiEx: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
          alu_ctrl  = ALU_ADD;
        end
        StMemRd: begin
          iord     = 1'b1;
          mem_read = 1'b1;
        end
        StMemWb: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
        end
        StMemWr: begin
          iord      = 1'b1;
          mem_write = 1'b1;
        end
        StExec: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_RT;
          alu_ctrl  = dec_alu_ctrl;
        end
        StAluWb: begin
          reg_write = 1'b1;
          reg_dst   = 1'b1;
        end
        StBranch: begin
          alu_src_a     = 1'b1;
          alu_src_b     = SRCB_RT;
          alu_ctrl      = ALU_SUB;
          pc_write_cond = 1'b1;
          pc_src        = PC_SRC_ALUOUT;
        end
        StAddiWb: reg_write = 1'b1;
        StJump: begin
          pc_write = 1'b1;
          pc_src   = PC_SRC_JUMP;
        end
        StIllegal: illegal = 1'b1;
        StHalt:    halted  = 1'b1;
        default: ;
      endcase
    end
  end

  assign instr_count = count_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Bench for mc_ctrl_fsm. Two instances share all inputs: dut0 (CNT_W=32,
// refetch on illegal) and dut1 (CNT_W=2 so the counter wraps quickly,
// halt on illegal). Per-cycle expected outputs are queued, then replayed.
module tb_mc_ctrl_fsm;

  localparam int S_RST = -1;
  localparam int S_FETCH = 0, S_DECODE = 1, S_MEMADR = 2, S_MEMRD = 3, S_MEMWB = 4;
  localparam int S_MEMWR = 5, S_EXEC = 6, S_ALUWB = 7, S_BRANCH = 8, S_ADDIEX = 9;
  localparam int S_ADDIWB = 10, S_JUMP = 11, S_ILLEGAL = 12, S_HALT = 13;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [5:0] opcode = '0, funct = '0;
  logic zero = 1'b0, mem_ready = 1'b1;

  logic pcw0, pwc0, iord0, mrd0, mwr0, irw0, rw0, rd0, m2r0, sa0, ill0, hlt0;
  logic [1:0] sb0, ps0;
  logic [2:0] ac0;
  logic [31:0] cnt0;
  logic pcw1, pwc1, iord1, mrd1, mwr1, irw1, rw1, rd1, m2r1, sa1, ill1, hlt1;
  logic [1:0] sb1, ps1;
  logic [2:0] ac1;
  logic [1:0] cnt1;

  logic [18:0] out0, out1;
  assign out0 = {pcw0, pwc0, iord0, mrd0, mwr0, irw0, rw0, rd0, m2r0, sa0, sb0, ac0, ps0,
                 ill0, hlt0};
  assign out1 = {pcw1, pwc1, iord1, mrd1, mwr1, irw1, rw1, rd1, m2r1, sa1, sb1, ac1, ps1,
                 ill1, hlt1};

  always #5 clk = ~clk;

  mc_ctrl_fsm #(.CNT_W(32), .ILLEGAL_HALT(1'b0)) dut0 (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pc_write(pcw0), .pc_write_cond(pwc0), .iord(iord0),
    .mem_read(mrd0), .mem_write(mwr0), .ir_write(irw0), .reg_write(rw0), .reg_dst(rd0),
    .mem_to_reg(m2r0), .alu_src_a(sa0), .alu_src_b(sb0), .alu_ctrl(ac0), .pc_src(ps0),
    .illegal(ill0), .halted(hlt0), .instr_count(cnt0)
  );

  mc_ctrl_fsm #(.CNT_W(2), .ILLEGAL_HALT(1'b1)) dut1 (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pc_write(pcw1), .pc_write_cond(pwc1), .iord(iord1),
    .mem_read(mrd1), .mem_write(mwr1), .ir_write(irw1), .reg_write(rw1), .reg_dst(rd1),
    .mem_to_reg(m2r1), .alu_src_a(sa1), .alu_src_b(sb1), .alu_ctrl(ac1), .pc_src(ps1),
    .illegal(ill1), .halted(hlt1), .instr_count(cnt1)
  );

  typedef struct {
    string       tag;
    logic        rst, mr, zero;
    logic [5:0]  op, fn;
    logic [18:0] e0, e1;
    logic [31:0] n0;
    logic [1:0]  n1;
  } item_t;

  item_t scb[$];
  logic [5:0] s_op = '0, s_fn = '0;
  logic s_zero = 1'b0;
  int unsigned m0 = 0, m1 = 0;
  int ncmp = 0, nerr = 0;

  // Expected output bundle for a state, from the control table.
  function automatic logic [18:0] ov(int st, logic mr, logic [2:0] alu);
    logic pcw, pwc, io, rd_s, wr_s, irw, rw, rdst, m2r, sa, ill, hlt;
    logic [1:0] sb, ps;
    logic [2:0] ac;
    {pcw, pwc, io, rd_s, wr_s, irw, rw, rdst, m2r, sa, ill, hlt} = '0;
    sb = 2'b00; ps = 2'b00; ac = 3'b000;
    case (st)
      S_FETCH:   begin rd_s = 1; sb = 2'b01; ac = 3'b010; irw = mr; pcw = mr; end
      S_DECODE:  begin sb = 2'b11; ac = 3'b010; end
      S_MEMADR:  begin sa = 1; sb = 2'b10; ac = 3'b010; end
      S_MEMRD:   begin io = 1; rd_s = 1; end
      S_MEMWB:   begin rw = 1; m2r = 1; end
      S_MEMWR:   begin io = 1; wr_s = 1; end
      S_EXEC:    begin sa = 1; ac = alu; end
      S_ALUWB:   begin rw = 1; rdst = 1; end
      S_BRANCH:  begin sa = 1; ac = 3'b110; pwc = 1; ps = 2'b01; end
      S_ADDIEX:  begin sa = 1; sb = 2'b10; ac = 3'b010; end
      S_ADDIWB:  rw = 1;
      S_JUMP:    begin pcw = 1; ps = 2'b10; end
      S_ILLEGAL: ill = 1;
      S_HALT:    hlt = 1;
      default: ;
    endcase
    return {pcw, pwc, io, rd_s, wr_s, irw, rw, rdst, m2r, sa, sb, ac, ps, ill, hlt};
  endfunction

  task automatic push(string tag, int st0, int st1, logic mr, logic [2:0] alu,
                      bit r0, bit r1);
    item_t it;
    it.tag = tag; it.rst = 1'b0; it.mr = mr; it.zero = s_zero;
    it.op = s_op; it.fn = s_fn;
    it.e0 = ov(st0, mr, alu); it.e1 = ov(st1, mr, alu);
    it.n0 = m0; it.n1 = m1[1:0];
    scb.push_back(it);
    if (r0) m0++;
    if (r1) m1++;
  endtask

  task automatic p(string tag, int st, logic mr, logic [2:0] alu, bit r);
    push(tag, st, st, mr, alu, r, r);
  endtask

  task automatic t_rst(int n);
    item_t it;
    for (int i = 0; i < n; i++) begin
      it.tag = "reset"; it.rst = 1'b1; it.mr = 1'b1; it.zero = 1'b0;
      it.op = '0; it.fn = '0; it.e0 = '0; it.e1 = '0; it.n0 = '0; it.n1 = '0;
      scb.push_back(it);
    end
    m0 = 0; m1 = 0;
  endtask

  task automatic drain();
    item_t it;
    while (scb.size() > 0) begin
      it = scb.pop_front();
      rst = it.rst; opcode = it.op; funct = it.fn; zero = it.zero; mem_ready = it.mr;
      @(negedge clk);
      ncmp++;
      assert (out0 === it.e0) else begin
        nerr++;
        $error("FAIL %s dut0 outputs got %05h exp %05h", it.tag, out0, it.e0);
      end
      ncmp++;
      assert (out1 === it.e1) else begin
        nerr++;
        $error("FAIL %s dut1 outputs got %05h exp %05h", it.tag, out1, it.e1);
      end
      if (!it.rst) begin
        ncmp++;
        assert (cnt0 === it.n0) else begin
          nerr++;
          $error("FAIL %s dut0 instr_count got %0d exp %0d", it.tag, cnt0, it.n0);
        end
        ncmp++;
        assert (cnt1 === it.n1) else begin
          nerr++;
          $error("FAIL %s dut1 instr_count got %0d exp %0d", it.tag, cnt1, it.n1);
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic t_rtype(string tag, logic [5:0] fn, logic [2:0] alu);
    s_op = 6'b000000; s_fn = fn;
    p({tag, ".fetch"}, S_FETCH, 1'b1, 3'b0, 1'b0);
    p({tag, ".decode"}, S_DECODE, 1'b1, 3'b0, 1'b0);
    p({tag, ".exec"}, S_EXEC, 1'b1, alu, 1'b0);
    p({tag, ".aluwb"}, S_ALUWB, 1'b1, 3'b0, 1'b1);
    drain();
  endtask

  task automatic t_short(string tag, logic [5:0] op, logic z, int st);
    s_op = op; s_zero = z;
    p({tag, ".fetch"}, S_FETCH, 1'b1, 3'b0, 1'b0);
    p({tag, ".decode"}, S_DECODE, 1'b1, 3'b0, 1'b0);
    p({tag, ".exe"}, st, 1'b1, 3'b0, 1'b1);
    drain();
  endtask

  initial begin
    t_rst(2);
    drain();

    t_rtype("add", 6'b100000, 3'b010);

    // lw with three memory stalls in MEMRD, plus one FETCH stall
    s_op = 6'b100011;
    p("lw.fetch_stall", S_FETCH, 1'b0, 3'b0, 1'b0);
    p("lw.fetch", S_FETCH, 1'b1, 3'b0, 1'b0);
    p("lw.decode", S_DECODE, 1'b1, 3'b0, 1'b0);
    p("lw.memadr", S_MEMADR, 1'b1, 3'b0, 1'b0);
    for (int i = 0; i < 3; i++) p("lw.memrd_stall", S_MEMRD, 1'b0, 3'b0, 1'b0);
    p("lw.memrd", S_MEMRD, 1'b1, 3'b0, 1'b0);
    p("lw.memwb", S_MEMWB, 1'b1, 3'b0, 1'b1);
    drain();

    t_short("beq_z1", 6'b000100, 1'b1, S_BRANCH);
    // dut1 counter now 3; this retire wraps it to 0
    t_short("j_wrap", 6'b000010, 1'b0, S_JUMP);
    t_short("beq_z0", 6'b000100, 1'b0, S_BRANCH);

    s_op = 6'b001000;
    p("addi.fetch", S_FETCH, 1'b1, 3'b0, 1'b0);
    p("addi.decode", S_DECODE, 1'b1, 3'b0, 1'b0);
    p("addi.ex", S_ADDIEX, 1'b0, 3'b0, 1'b0);
    p("addi.wb", S_ADDIWB, 1'b0, 3'b0, 1'b1);
    drain();

    s_op = 6'b101011;
    p("sw.fetch", S_FETCH, 1'b1, 3'b0, 1'b0);
    p("sw.decode", S_DECODE, 1'b1, 3'b0, 1'b0);
    p("sw.memadr", S_MEMADR, 1'b1, 3'b0, 1'b0);
    p("sw.memwr_stall", S_MEMWR, 1'b0, 3'b0, 1'b0);
    p("sw.memwr", S_MEMWR, 1'b1, 3'b0, 1'b1);
    drain();

    t_rtype("sub", 6'b100010, 3'b110);
    t_rtype("and", 6'b100100, 3'b000);
    t_rtype("or", 6'b100101, 3'b001);
    t_rtype("slt", 6'b101010, 3'b111);

    // sw aborted by reset during a MEMWR stall
    s_op = 6'b101011;
    p("swrst.fetch", S_FETCH, 1'b1, 3'b0, 1'b0);
    p("swrst.decode", S_DECODE, 1'b1, 3'b0, 1'b0);
    p("swrst.memadr", S_MEMADR, 1'b1, 3'b0, 1'b0);
    p("swrst.memwr_stall", S_MEMWR, 1'b0, 3'b0, 1'b0);
    p("swrst.memwr_stall", S_MEMWR, 1'b0, 3'b0, 1'b0);
    t_rst(1);
    s_op = 6'b101011;
    p("swrst.after", S_FETCH, 1'b0, 3'b0, 1'b0);
    drain();

    // Illegal opcode: dut0 refetches, dut1 parks in HALT
    s_op = 6'b111111;
    p("illop.fetch", S_FETCH, 1'b1, 3'b0, 1'b0);
    p("illop.decode", S_DECODE, 1'b1, 3'b0, 1'b0);
    p("illop.illegal", S_ILLEGAL, 1'b1, 3'b0, 1'b0);
    drain();

    // Bad funct on dut0 while dut1 stays halted
    s_op = 6'b000000; s_fn = 6'b000111;
    push("badfn.fetch", S_FETCH, S_HALT, 1'b1, 3'b0, 1'b0, 1'b0);
    push("badfn.decode", S_DECODE, S_HALT, 1'b1, 3'b0, 1'b0, 1'b0);
    push("badfn.exec", S_EXEC, S_HALT, 1'b1, 3'b000, 1'b0, 1'b0);
    push("badfn.illegal", S_ILLEGAL, S_HALT, 1'b0, 3'b0, 1'b0, 1'b0);
    push("badfn.refetch", S_FETCH, S_HALT, 1'b0, 3'b0, 1'b0, 1'b0);
    push("badfn.refetch", S_FETCH, S_HALT, 1'b1, 3'b0, 1'b0, 1'b0);
    s_op = 6'b000010;
    push("halt.j_dut0", S_DECODE, S_HALT, 1'b1, 3'b0, 1'b0, 1'b0);
    push("halt.j_dut0", S_JUMP, S_HALT, 1'b1, 3'b0, 1'b1, 1'b0);
    drain();

    t_rst(1);
    drain();
    t_rtype("add_after_halt", 6'b100000, 3'b010);
    s_op = 6'b000000;
    p("final.fetch", S_FETCH, 1'b0, 3'b0, 1'b0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
